// File: rtl/ram_line_arbiter_pkg.sv
// Shared types and constants for the cache-line RAM arbiter.
// Line geometry helpers live here so every unit agrees on them.
package ram_line_arbiter_pkg;

  localparam int BLK_SIZE = 128;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RSP
  } ram_arb_state_e;

  typedef enum logic {
    OWN_IC,
    OWN_DC
  } ram_owner_e;

  function automatic int line_addr_bits(input int line_w);
    return $clog2(line_w / 32);
  endfunction

  localparam int LINE_ADDR_BITS = line_addr_bits(BLK_SIZE);

endpackage

// File: rtl/ram_line_arbiter_rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// prefer = 0 favours req[0], prefer = 1 favours req[1].
module ram_rr_pick2 (
  input  logic [1:0] req,
  input  logic       prefer,
  output logic [1:0] gnt,
  output logic       next_prefer
);

  // One-hot grant; preference flips away from the winner
  always_comb begin
    gnt         = 2'b00;
    next_prefer = prefer;
    unique case (1'b1)
      (req[0] && (!req[1] || !prefer)): begin
        gnt         = 2'b01;
        next_prefer = 1'b1;
      end
      (req[1] && (!req[0] || prefer)): begin
        gnt         = 2'b10;
        next_prefer = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_line_arbiter.sv
// Shares the single-port line-wide RAM between icache and dcache.
// One transaction in flight; responses buffered until handshaken.
module ram_line_arbiter
  import ram_line_arbiter_pkg::*;
#(
  parameter  int LINE_W    = BLK_SIZE,
  parameter  int RAM_DEPTH = 32768,
  localparam int ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hold_i,
  input  logic                ic_req_valid_i,
  output logic                ic_req_ready_o,
  input  logic [ADDR_W-1:0]   ic_req_addr_i,
  output logic                ic_rsp_valid_o,
  input  logic                ic_rsp_ready_i,
  output logic [LINE_W-1:0]   ic_rsp_data_o,
  input  logic                dc_req_valid_i,
  output logic                dc_req_ready_o,
  input  logic [ADDR_W-1:0]   dc_req_addr_i,
  input  logic                dc_req_we_i,
  input  logic [LINE_W-1:0]   dc_req_wdata_i,
  input  logic [LINE_W/8-1:0] dc_req_wstrb_i,
  output logic                dc_rsp_valid_o,
  input  logic                dc_rsp_ready_i,
  output logic [LINE_W-1:0]   dc_rsp_data_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [LINE_W-1:0]   ram_wdata_o,
  output logic [LINE_W/8-1:0] ram_wstrb_o,
  output logic                ram_rd_en_o,
  input  logic [LINE_W-1:0]   ram_rdata_i
);

  localparam int LAB = line_addr_bits(LINE_W);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~ADDR_W'((1 << LAB) - 1);

  ram_arb_state_e state_q, state_d;
  ram_owner_e     owner_q;
  logic           rr_q;
  logic [LINE_W-1:0] rsp_data_q;

  logic [1:0] gnt;
  logic       next_prefer;
  logic       grant_en;
  logic       ic_win;
  logic       dc_win;
  logic       owner_ack;

  ram_rr_pick2 u_pick (
    .req         ({dc_req_valid_i, ic_req_valid_i}),
    .prefer      (rr_q),
    .gnt         (gnt),
    .next_prefer (next_prefer)
  );

  assign grant_en = (state_q == IDLE) && !hold_i;
  assign ic_win   = grant_en && gnt[0];
  assign dc_win   = grant_en && gnt[1];
  assign owner_ack = (owner_q == OWN_IC) ? ic_rsp_ready_i
                                         : dc_rsp_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: writes skip the read wait and ack directly
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dc_win && dc_req_we_i)  state_d = RSP;
        else if (ic_win || dc_win)  state_d = RD_WAIT;
      end
      RD_WAIT: state_d = RSP;
      RSP:     if (owner_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner, round-robin pointer and response buffer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q    <= OWN_IC;
      rr_q       <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (ic_win || dc_win) begin
        owner_q <= dc_win ? OWN_DC : OWN_IC;
        rr_q    <= next_prefer;
        if (dc_win && dc_req_we_i) rsp_data_q <= '0;
      end
      if (state_q == RD_WAIT) rsp_data_q <= ram_rdata_i;
    end
  end

  // Handshake and RAM drive; RAM is idle outside the accept cycle
  always_comb begin
    ic_req_ready_o = ic_win;
    dc_req_ready_o = dc_win;
    ic_rsp_valid_o = (state_q == RSP) && (owner_q == OWN_IC);
    dc_rsp_valid_o = (state_q == RSP) && (owner_q == OWN_DC);
    ic_rsp_data_o  = ic_rsp_valid_o ? rsp_data_q : '0;
    dc_rsp_data_o  = dc_rsp_valid_o ? rsp_data_q : '0;
    ram_addr_o     = '0;
    ram_wdata_o    = '0;
    ram_wstrb_o    = '0;
    ram_rd_en_o    = 1'b0;
    if (ic_win) begin
      ram_addr_o  = ic_req_addr_i & LINE_MASK;
      ram_rd_en_o = 1'b1;
    end else if (dc_win) begin
      ram_addr_o = dc_req_addr_i & LINE_MASK;
      if (dc_req_we_i) begin
        ram_wdata_o = dc_req_wdata_i;
        ram_wstrb_o = dc_req_wstrb_i;
      end else begin
        ram_rd_en_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_line_arbiter.sv
// Directed bench for ram_line_arbiter: grant order, latency,
// response hold, hold_i gating and reset recovery.
module tb_ram_line_arbiter;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         hold_i;
  logic         ic_req_valid_i;
  logic         ic_req_ready_o;
  logic [14:0]  ic_req_addr_i;
  logic         ic_rsp_valid_o;
  logic         ic_rsp_ready_i;
  logic [127:0] ic_rsp_data_o;
  logic         dc_req_valid_i;
  logic         dc_req_ready_o;
  logic [14:0]  dc_req_addr_i;
  logic         dc_req_we_i;
  logic [127:0] dc_req_wdata_i;
  logic [15:0]  dc_req_wstrb_i;
  logic         dc_rsp_valid_o;
  logic         dc_rsp_ready_i;
  logic [127:0] dc_rsp_data_o;
  logic [14:0]  ram_addr_o;
  logic [127:0] ram_wdata_o;
  logic [15:0]  ram_wstrb_o;
  logic         ram_rd_en_o;
  logic [127:0] ram_rdata_i;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] LINE_A = 128'hDEADBEEF;
  localparam logic [127:0] LINE_B = 128'h0123_4567_89AB_CDEF_0000_1111_2222_3333;
  localparam logic [127:0] LINE_C = 128'hCAFE_F00D_0000_0000_0000_0000_5555_AAAA;
  localparam logic [127:0] LINE_D = 128'h7777_0000_0000_0000_0000_0000_0000_8888;

  ram_line_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .hold_i         (hold_i),
    .ic_req_valid_i (ic_req_valid_i),
    .ic_req_ready_o (ic_req_ready_o),
    .ic_req_addr_i  (ic_req_addr_i),
    .ic_rsp_valid_o (ic_rsp_valid_o),
    .ic_rsp_ready_i (ic_rsp_ready_i),
    .ic_rsp_data_o  (ic_rsp_data_o),
    .dc_req_valid_i (dc_req_valid_i),
    .dc_req_ready_o (dc_req_ready_o),
    .dc_req_addr_i  (dc_req_addr_i),
    .dc_req_we_i    (dc_req_we_i),
    .dc_req_wdata_i (dc_req_wdata_i),
    .dc_req_wstrb_i (dc_req_wstrb_i),
    .dc_rsp_valid_o (dc_rsp_valid_o),
    .dc_rsp_ready_i (dc_rsp_ready_i),
    .dc_rsp_data_o  (dc_rsp_data_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_wstrb_o    (ram_wstrb_o),
    .ram_rd_en_o    (ram_rd_en_o),
    .ram_rdata_i    (ram_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; hold_i = 1'b0;
    ic_req_valid_i = 1'b0; ic_req_addr_i = '0; ic_rsp_ready_i = 1'b0;
    dc_req_valid_i = 1'b0; dc_req_addr_i = '0; dc_req_we_i = 1'b0;
    dc_req_wdata_i = '0; dc_req_wstrb_i = '0; dc_rsp_ready_i = 1'b0;
    ram_rdata_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("rst_ic_rsp_valid", 128'(ic_rsp_valid_o), 128'(0));
    chk("rst_dc_rsp_valid", 128'(dc_rsp_valid_o), 128'(0));
    chk("rst_rd_en", 128'(ram_rd_en_o), 128'(0));
    chk("rst_wstrb", 128'(ram_wstrb_o), 128'(0));
    chk("rst_addr", 128'(ram_addr_o), 128'(0));
    chk("rst_wdata", ram_wdata_o, 128'(0));
    chk("rst_ic_data", ic_rsp_data_o, 128'(0));

    // icache read at 0x0010
    ic_req_valid_i = 1'b1; ic_req_addr_i = 15'h0010;
    #1;
    chk("rd_ic_ready", 128'(ic_req_ready_o), 128'(1));
    chk("rd_rd_en", 128'(ram_rd_en_o), 128'(1));
    chk("rd_addr", 128'(ram_addr_o), 128'h0010);
    chk("rd_wstrb", 128'(ram_wstrb_o), 128'(0));
    tick();
    ic_req_valid_i = 1'b0; ram_rdata_i = LINE_A;
    #1;
    chk("rd_t1_valid", 128'(ic_rsp_valid_o), 128'(0));
    chk("rd_t1_rd_en", 128'(ram_rd_en_o), 128'(0));
    tick();
    ram_rdata_i = '0;
    #1;
    chk("rd_t2_valid", 128'(ic_rsp_valid_o), 128'(1));
    chk("rd_t2_data", ic_rsp_data_o, LINE_A);
    chk("rd_t2_dc_valid", 128'(dc_rsp_valid_o), 128'(0));
    ic_rsp_ready_i = 1'b1;
    tick();
    ic_rsp_ready_i = 1'b0;
    #1;
    chk("rd_done_valid", 128'(ic_rsp_valid_o), 128'(0));

    // dcache write at 0x0104
    dc_req_valid_i = 1'b1; dc_req_addr_i = 15'h0104; dc_req_we_i = 1'b1;
    dc_req_wstrb_i = 16'h000F; dc_req_wdata_i = 128'h12345678;
    #1;
    chk("wr_dc_ready", 128'(dc_req_ready_o), 128'(1));
    chk("wr_ic_ready", 128'(ic_req_ready_o), 128'(0));
    chk("wr_wstrb", 128'(ram_wstrb_o), 128'h000F);
    chk("wr_addr", 128'(ram_addr_o), 128'h0104);
    chk("wr_wdata", ram_wdata_o, 128'h12345678);
    chk("wr_rd_en", 128'(ram_rd_en_o), 128'(0));
    tick();
    dc_req_valid_i = 1'b0; dc_req_we_i = 1'b0; dc_req_wstrb_i = '0;
    #1;
    chk("wr_t1_valid", 128'(dc_rsp_valid_o), 128'(1));
    chk("wr_t1_data", dc_rsp_data_o, 128'(0));
    chk("wr_t1_wstrb", 128'(ram_wstrb_o), 128'(0));
    chk("wr_t1_ic_valid", 128'(ic_rsp_valid_o), 128'(0));
    dc_rsp_ready_i = 1'b1;
    tick();
    dc_rsp_ready_i = 1'b0;

    // both valid: icache first, dcache after, then icache again
    ic_req_valid_i = 1'b1; ic_req_addr_i = 15'h0023;
    dc_req_valid_i = 1'b1; dc_req_addr_i = 15'h0200;
    #1;
    chk("rr1_ic_ready", 128'(ic_req_ready_o), 128'(1));
    chk("rr1_dc_ready", 128'(dc_req_ready_o), 128'(0));
    chk("rr1_addr_mask", 128'(ram_addr_o), 128'h0020);
    tick();
    ram_rdata_i = LINE_B;
    #1;
    chk("rr1_wait_ic_ready", 128'(ic_req_ready_o), 128'(0));
    chk("rr1_wait_dc_ready", 128'(dc_req_ready_o), 128'(0));
    tick();
    ram_rdata_i = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_rsp_valid", 128'(ic_rsp_valid_o), 128'(1));
      chk("hold_rsp_data", ic_rsp_data_o, LINE_B);
      chk("hold_dc_ready", 128'(dc_req_ready_o), 128'(0));
      tick();
    end
    ic_rsp_ready_i = 1'b1;
    tick();
    ic_rsp_ready_i = 1'b0;
    #1;
    chk("rr2_dc_ready", 128'(dc_req_ready_o), 128'(1));
    chk("rr2_ic_ready", 128'(ic_req_ready_o), 128'(0));
    chk("rr2_addr", 128'(ram_addr_o), 128'h0200);
    chk("rr2_rd_en", 128'(ram_rd_en_o), 128'(1));
    tick();
    ram_rdata_i = LINE_C;
    tick();
    ram_rdata_i = '0;
    #1;
    chk("rr2_dc_valid", 128'(dc_rsp_valid_o), 128'(1));
    chk("rr2_dc_data", dc_rsp_data_o, LINE_C);
    chk("rr2_ic_valid", 128'(ic_rsp_valid_o), 128'(0));
    dc_rsp_ready_i = 1'b1;
    tick();
    dc_rsp_ready_i = 1'b0;
    #1;
    chk("rr3_ic_ready", 128'(ic_req_ready_o), 128'(1));
    chk("rr3_dc_ready", 128'(dc_req_ready_o), 128'(0));

    // hold_i blocks grants while both request
    hold_i = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_ic_ready", 128'(ic_req_ready_o), 128'(0));
      chk("hold_dc_ready", 128'(dc_req_ready_o), 128'(0));
      chk("hold_rd_en", 128'(ram_rd_en_o), 128'(0));
      chk("hold_wstrb", 128'(ram_wstrb_o), 128'(0));
      tick();
    end
    hold_i = 1'b0;
    dc_req_valid_i = 1'b0;
    #1;
    chk("unhold_ic_ready", 128'(ic_req_ready_o), 128'(1));
    tick();
    hold_i = 1'b1; ic_req_valid_i = 1'b0; ram_rdata_i = LINE_D;
    tick();
    ram_rdata_i = '0;
    #1;
    chk("hold_mid_valid", 128'(ic_rsp_valid_o), 128'(1));
    chk("hold_mid_data", ic_rsp_data_o, LINE_D);
    ic_rsp_ready_i = 1'b1;
    tick();
    ic_rsp_ready_i = 1'b0; hold_i = 1'b0;

    // reset during RD_WAIT restores icache preference
    ic_req_valid_i = 1'b1; ic_req_addr_i = 15'h0040;
    #1;
    chk("pre_rst_ic_ready", 128'(ic_req_ready_o), 128'(1));
    tick();
    ic_req_valid_i = 1'b0; rst_i = 1'b1; ram_rdata_i = LINE_A;
    tick();
    rst_i = 1'b0; ram_rdata_i = '0;
    #1;
    chk("post_rst_ic_valid", 128'(ic_rsp_valid_o), 128'(0));
    chk("post_rst_dc_valid", 128'(dc_rsp_valid_o), 128'(0));
    ic_req_valid_i = 1'b1; dc_req_valid_i = 1'b1;
    #1;
    chk("post_rst_ic_ready", 128'(ic_req_ready_o), 128'(1));
    chk("post_rst_dc_ready", 128'(dc_req_ready_o), 128'(0));
    chk("post_rst_rd_en", 128'(ram_rd_en_o), 128'(1));

    ic_req_valid_i = 1'b0; dc_req_valid_i = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
